quad_decoder: RTL

- Quadrature encoder front-end for the Computer Architecture Elements Catalog.
- Takes two asynchronous encoder channels (a, b), synchronizes and debounces them, and decodes Gray-code transitions.
- Produces a one-cycle step pulse plus a direction level, which drive the enable and up/down inputs of the downstream up/down counter.
- Flags illegal (double-bit) transitions.

---
 rtl/quad_pkg.sv | 20 ++
 rtl/quad_debounce.sv | 44 ++++
 rtl/quad_decoder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared types and the Gray-code transition decoder for the quadrature front-end.
package quad_pkg;

    typedef enum logic [0:0] {ST_INIT, ST_TRACK} quad_state_t;

    typedef logic [1:0] quad_ab_t;

    // Returns {valid, up, illegal}; cur/prev are {a, b}.
    function automatic logic [2:0] decode(quad_ab_t prev, quad_ab_t cur);
        quad_ab_t diff;
        logic     valid;
        logic     up;
        diff  = prev ^ cur;
        valid = ^diff;
        // Forward steps are exactly those where old a differs from new b.
        up    = prev[1] ^ cur[0];
        return {valid, valid & up, &diff};
    endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder channel: multi-flop synchronizer followed by a consecutive-cycle debounce filter.
module quad_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic init,
    output logic sync,
    output logic filt
);

    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   filt_q;

    assign sync = sync_q[SYNC_STAGES-1];
    assign filt = filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            if (init) begin
                filt_q <= sync;
                cnt_q  <= '0;
            end else if (sync == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
                filt_q <= sync;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front-end: filtered A/B channels decoded into step/dir pulses with
// illegal-transition flagging.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic enable,
    input  logic clr_err,
    output logic step,
    output logic dir,
    output logic err,
    output logic err_sticky,
    output logic ready
);

    localparam int unsigned IW = $clog2(SYNC_STAGES + 1);

    quad_state_t    state_q, state_d;
    logic [IW-1:0]  init_cnt_q, init_cnt_d;
    quad_ab_t       prev_q, prev_d;
    logic           step_q, step_d;
    logic           dir_q, dir_d;
    logic           err_q, err_d;
    logic           sticky_q, sticky_d;
    logic           ready_q, ready_d;
    logic           in_init;
    logic           sync_a, sync_b, filt_a, filt_b;
    quad_ab_t       cur;
    logic [2:0]     dec;

    assign in_init = (state_q == ST_INIT);

    quad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_deb_a (
        .clk  (clk),
        .rst  (rst),
        .din  (a),
        .init (in_init),
        .sync (sync_a),
        .filt (filt_a)
    );

    quad_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_deb_b (
        .clk  (clk),
        .rst  (rst),
        .din  (b),
        .init (in_init),
        .sync (sync_b),
        .filt (filt_b)
    );

    assign cur = {filt_a, filt_b};
    assign dec = decode(prev_q, cur);

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = prev_q;
        step_d     = 1'b0;
        err_d      = 1'b0;
        dir_d      = dir_q;
        ready_d    = ready_q;
        unique case (state_q)
            ST_INIT: begin
                // Track what filt is loading so prev == filt at the hand-off to TRACK.
                prev_d = {sync_a, sync_b};
                if (init_cnt_q == IW'(SYNC_STAGES)) begin
                    state_d = ST_TRACK;
                    ready_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_TRACK: begin
                prev_d = cur;
                if (dec[2]) begin
                    dir_d  = dec[1];
                    step_d = enable;
                end
                err_d = dec[0];
            end
            default: state_d = ST_INIT;
        endcase
        // Setting wins over clearing, including while the err pulse is still visible.
        if (err_d || err_q) begin
            sticky_d = 1'b1;
        end else if (clr_err) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            prev_q     <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
            sticky_q   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_q     <= prev_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
            ready_q    <= ready_d;
        end
    end

    assign step       = step_q;
    assign dir        = dir_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign ready      = ready_q;

endmodule
